// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB control path: arbiter state encoding,
// SCCB field widths and the camera device ID used by the master instance.
package sccb_pkg;

   localparam int SCCB_ADDR_W = 8;
   localparam int SCCB_DATA_W = 8;

   // OV2640 write address on the SCCB bus, consumed by the master instance
   localparam logic [7:0] OV2640_DEV_ID = 8'h60;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_IDLE = 2'd2
   } sccb_state_t;

endpackage

// File: rtl/sccb_rr_pick.sv
// Combinational round-robin pick: first set request bit found searching
// upward from rr_ptr, wrapping past the top requester back to zero.
module sccb_rr_pick #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       rr_ptr,
   output logic             found,
   output logic [1:0]       idx
);

   localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);

   // rot_idx[k] is the requester k positions above the pointer
   logic [1:0]       rot_idx [N_REQ];
   logic [N_REQ-1:0] rot_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_off
         logic [2:0] sum;
         assign sum          = {1'b0, rr_ptr} + 3'(gi);
         assign rot_idx[gi]  = (sum >= 3'(N_REQ)) ? 2'(sum - 3'(N_REQ)) : sum[1:0];
         assign rot_hit[gi]  = |(req & (REQ_ONE << rot_idx[gi]));
      end
   endgenerate

   // Smallest offset wins, so scan from the farthest candidate down
   always_comb begin
      found = |rot_hit;
      idx   = 2'd0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_hit[k]) idx = rot_idx[k];
      end
   end

endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master between N_REQ requesters.
// A grant is held for a whole transaction; a watchdog drops commands the
// master never takes. All outputs are registered.
module sccb_arbiter
   import sccb_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int CNT_W       = 20
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req,
   input  logic [SCCB_ADDR_W*N_REQ-1:0] req_rega,
   input  logic [SCCB_DATA_W*N_REQ-1:0] req_value,
   output logic [N_REQ-1:0]             ack,
   output logic [N_REQ-1:0]             err,
   output logic [1:0]                   grant_id,
   output logic                         busy,
   output logic                         m_send,
   output logic [SCCB_ADDR_W-1:0]       m_rega,
   output logic [SCCB_DATA_W-1:0]       m_value,
   input  logic                         m_taken,
   input  logic                         m_idle
);

   localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0]       LAST_ID = 2'(N_REQ - 1);

   sccb_state_t            state_reg, state_next;
   logic [CNT_W-1:0]       wd_reg, wd_next;
   logic [1:0]             rr_ptr_reg, rr_ptr_next;
   logic [1:0]             grant_reg, grant_next;
   logic                   m_send_reg, m_send_next;
   logic [SCCB_ADDR_W-1:0] rega_reg, rega_next;
   logic [SCCB_DATA_W-1:0] value_reg, value_next;
   logic [N_REQ-1:0]       ack_reg, ack_next;
   logic [N_REQ-1:0]       err_reg, err_next;
   logic                   busy_reg, busy_next;

   logic                   pick_found;
   logic [1:0]             pick_idx;
   logic [1:0]             rr_after;

   sccb_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_reg),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   // Pointer moves just past the requester that finished (ack or err)
   assign rr_after = (grant_reg == LAST_ID) ? 2'd0 : grant_reg + 2'd1;

   // Next-state and next-output logic for the grant FSM and watchdog
   always_comb begin
      state_next  = state_reg;
      wd_next     = wd_reg;
      rr_ptr_next = rr_ptr_reg;
      grant_next  = grant_reg;
      m_send_next = m_send_reg;
      rega_next   = rega_reg;
      value_next  = value_reg;
      ack_next    = '0;
      err_next    = '0;

      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               for (int i = 0; i < N_REQ; i++) begin
                  if (pick_idx == 2'(i)) begin
                     rega_next  = req_rega[i*SCCB_ADDR_W +: SCCB_ADDR_W];
                     value_next = req_value[i*SCCB_DATA_W +: SCCB_DATA_W];
                  end
               end
               grant_next  = pick_idx;
               m_send_next = 1'b1;
               wd_next     = '0;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            wd_next = wd_reg + 1'b1;
            // m_taken is checked first so it wins a tie with the timeout
            if (m_taken) begin
               m_send_next = 1'b0;
               ack_next    = REQ_ONE << grant_reg;
               rr_ptr_next = rr_after;
               state_next  = WAIT_IDLE;
            end else if (wd_reg == WD_LAST) begin
               m_send_next = 1'b0;
               err_next    = REQ_ONE << grant_reg;
               rr_ptr_next = rr_after;
               state_next  = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (m_idle) state_next = IDLE;
         end
         default: begin
            state_next  = IDLE;
            m_send_next = 1'b0;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   // State and output registers; reset clears everything at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         wd_reg     <= '0;
         rr_ptr_reg <= 2'd0;
         grant_reg  <= 2'd0;
         m_send_reg <= 1'b0;
         rega_reg   <= '0;
         value_reg  <= '0;
         ack_reg    <= '0;
         err_reg    <= '0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         wd_reg     <= wd_next;
         rr_ptr_reg <= rr_ptr_next;
         grant_reg  <= grant_next;
         m_send_reg <= m_send_next;
         rega_reg   <= rega_next;
         value_reg  <= value_next;
         ack_reg    <= ack_next;
         err_reg    <= err_next;
         busy_reg   <= busy_next;
      end
   end

   assign ack      = ack_reg;
   assign err      = err_reg;
   assign grant_id = grant_reg;
   assign busy     = busy_reg;
   assign m_send   = m_send_reg;
   assign m_rega   = rega_reg;
   assign m_value  = value_reg;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Bench for sccb_arbiter: a behavioural SCCB master answers m_send, a
// monitor pops expected grants from a queue and checks every transaction.
module tb_sccb_arbiter;

   localparam int N  = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_rega;
   logic [8*N-1:0] req_value;
   logic [N-1:0]  ack, err;
   logic [1:0]    grant_id;
   logic          busy, m_send, m_taken, m_idle;
   logic [7:0]    m_rega, m_value;

   sccb_arbiter #(
      .N_REQ       (N),
      .TIMEOUT_CYC (TO),
      .CNT_W       (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_rega  (req_rega),
      .req_value (req_value),
      .ack       (ack),
      .err       (err),
      .grant_id  (grant_id),
      .busy      (busy),
      .m_send    (m_send),
      .m_rega    (m_rega),
      .m_value   (m_value),
      .m_taken   (m_taken),
      .m_idle    (m_idle)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] rega;
      logic [7:0] value;
      bit         is_err;
      int         len;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cnt = 0;
   int   take_delay;   // 0 = master never takes
   int   idle_delay;
   bit   in_txn = 0;
   int   send_len = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic push_exp(input int idx, input logic [7:0] rega, input logic [7:0] value,
                           input bit is_err, input int len);
      exp_t e;
      e.idx = idx; e.rega = rega; e.value = value; e.is_err = is_err; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      check_val("wait_done", done_cnt, target);
   endtask

   // Behavioural SCCB master: takes after take_delay cycles, then idles
   initial begin
      int k;
      m_taken = 1'b0;
      m_idle  = 1'b1;
      forever begin
         tick();
         if (rst_n && m_send) begin
            m_idle = 1'b0;
            k = 0;
            while (m_send && (take_delay == 0 || k < take_delay - 1)) begin
               tick();
               k++;
            end
            if (m_send && take_delay > 0) begin
               m_taken = 1'b1;
               tick();
               m_taken = 1'b0;
            end
            repeat (idle_delay) tick();
            m_idle = 1'b1;
         end
      end
   end

   // Monitor: pops an expectation at each m_send rise, checks at ack/err
   always @(negedge clk) begin
      if (!rst_n) begin
         in_txn   = 0;
         send_len = 0;
      end else begin
         if (m_send) begin
            if (!in_txn) begin
               in_txn   = 1;
               send_len = 0;
               if (exp_q.size() == 0) begin
                  check_val("unexpected_send", 1, 0);
                  cur = '{0, 8'h00, 8'h00, 1'b0, 0};
               end else begin
                  cur = exp_q.pop_front();
                  check_val("grant_id", grant_id, cur.idx);
                  check_val("m_value", m_value, cur.value);
               end
            end
            send_len++;
            check_val("m_rega", m_rega, cur.rega);
            check_val("busy_send", busy, 1);
         end
         if ((ack | err) != 0) begin
            if (!in_txn) begin
               check_val("spurious_ack_err", {ack, err}, 0);
            end else begin
               check_val("ack", ack, cur.is_err ? 0 : (1 << cur.idx));
               check_val("err", err, cur.is_err ? (1 << cur.idx) : 0);
               check_val("send_len", send_len, cur.len);
               check_val("send_dropped", m_send, 0);
               $display("TXN grant=%0d rega=%h value=%h ack=%b err=%b send_cycles=%0d",
                        grant_id, m_rega, m_value, ack, err, send_len);
               in_txn = 0;
               done_cnt++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0d want=%0d", done_cnt, 10);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req = '0; req_rega = '0; req_value = '0;
      take_delay = 5; idle_delay = 4;
      repeat (3) tick();
      check_val("rst_m_send", m_send, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_grant", grant_id, 0);
      check_val("rst_ack_err", {ack, err}, 0);
      check_val("rst_rega_value", {m_rega, m_value}, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Single request, one-cycle latency to m_send
      req_rega[7:0] = 8'hFF; req_value[7:0] = 8'h01;
      push_exp(0, 8'hFF, 8'h01, 0, 5);
      req = 2'b01;
      @(negedge clk);
      check_val("latency_pre", m_send, 0);
      @(negedge clk);
      check_val("latency_one", m_send, 1);
      wait_done(1, 50);
      req = '0;
      repeat (8) tick();

      // Contention: pointer sits at 1 after the previous grant to 0
      take_delay = 3; idle_delay = 10;
      req_rega = {8'hB1, 8'hA0}; req_value = {8'h11, 8'h10};
      push_exp(1, 8'hB1, 8'h11, 0, 3);
      push_exp(0, 8'hA0, 8'h10, 0, 3);
      push_exp(1, 8'hB1, 8'h11, 0, 3);
      push_exp(0, 8'hA0, 8'h10, 0, 3);
      req = 2'b11;
      wait_done(5, 300);
      req = '0;
      repeat (15) tick();

      // Timeout on requester 1, then requester 0 is served
      take_delay = 0; idle_delay = 4;
      req_rega = {8'hC1, 8'hC0}; req_value = {8'h21, 8'h20};
      push_exp(1, 8'hC1, 8'h21, 1, TO);
      push_exp(0, 8'hC0, 8'h20, 0, 3);
      req = 2'b11;
      wait_done(6, 100);
      take_delay = 3;
      wait_done(7, 100);
      req = '0;
      repeat (8) tick();

      // Tie: m_taken lands on the last watchdog cycle
      take_delay = TO;
      req_rega[7:0] = 8'hD0; req_value[7:0] = 8'h30;
      push_exp(0, 8'hD0, 8'h30, 0, TO);
      req = 2'b01;
      wait_done(8, 100);
      req = '0;
      repeat (8) tick();

      // Address change during ISSUE must not reach the master
      take_delay = 8;
      req_rega[7:0] = 8'h12; req_value[7:0] = 8'h40;
      push_exp(0, 8'h12, 8'h40, 0, 8);
      req = 2'b01;
      repeat (2) tick();
      req_rega[7:0] = 8'h34;
      wait_done(9, 100);
      req = '0;
      repeat (8) tick();

      // Reset in the middle of ISSUE, then arbitration restarts at 0
      take_delay = 0;
      req_rega = {8'hE1, 8'hE0}; req_value = {8'h51, 8'h50};
      push_exp(1, 8'hE1, 8'h51, 0, 0);
      req = 2'b10;
      repeat (4) tick();
      check_val("pre_rst_send", m_send, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_m_send", m_send, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_grant", grant_id, 0);
      check_val("arst_ack_err", {ack, err}, 0);
      take_delay = 3;
      req = 2'b11;
      repeat (8) tick();
      push_exp(0, 8'hE0, 8'h50, 0, 3);
      rst_n = 1'b1;
      wait_done(10, 100);
      req = '0;
      repeat (8) tick();

      check_val("queue_empty", exp_q.size(), 0);
      check_val("txn_closed", in_txn, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
